// File: rtl/dp_arbiter_pkg.sv
// Shared definitions for the datapath arbiter/sequencer: state codes,
// per-state datapath control words and the step counter width.
package dp_arbiter_pkg;

    localparam int STEP_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LOAD   = 2'd1;
    localparam state_t ST_RUN    = 2'd2;
    localparam state_t ST_FINISH = 2'd3;

    typedef struct packed {
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       lx;
        logic       ls;
        logic       lh;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE   = '{m0: 2'b00, m1: 2'b00, m2: 2'b00, lx: 1'b0, ls: 1'b0, lh: 1'b0};
    localparam ctrl_t CTRL_LOAD   = '{m0: 2'b00, m1: 2'b00, m2: 2'b00, lx: 1'b1, ls: 1'b0, lh: 1'b1};
    localparam ctrl_t CTRL_RUN    = '{m0: 2'b01, m1: 2'b10, m2: 2'b01, lx: 1'b0, ls: 1'b1, lh: 1'b0};
    localparam ctrl_t CTRL_FINISH = '{m0: 2'b00, m1: 2'b00, m2: 2'b11, lx: 1'b0, ls: 1'b0, lh: 1'b0};

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: scans last+1, last+2, ... modulo NREQ and
// returns the first requester found as a one-hot vector plus its index.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [NREQ-1:0]  o_win,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    int               w_sel;
    logic [NREQ-1:0]  w_shift;

    always_comb begin
        o_win   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_sel   = 0;
        w_shift = '0;
        for (int off = 1; off <= NREQ; off++) begin
            w_sel   = (int'(i_last) + off) % NREQ;
            w_shift = i_req >> w_sel;
            if (!o_valid && w_shift[0]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(w_sel);
                o_win   = ONE << w_sel;
            end
        end
    end

endmodule

// File: rtl/dp_arbiter_seq.sv
// Round-robin owner selection plus the LOAD -> RUN x STEPS -> FINISH control
// sequence for the shared datapath; every output is a flop.
module dp_arbiter_seq
    import dp_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int STEPS = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic              abort,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic              busy,
    output logic [STEP_W-1:0] step,
    output logic [1:0]        m0,
    output logic [1:0]        m1,
    output logic [1:0]        m2,
    output logic              lx,
    output logic              ls,
    output logic              lh,
    output logic              h,
    output logic              done
);

    localparam int                IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

    state_t              r_state;
    ctrl_t               r_ctrl;
    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     r_ack;
    logic                r_busy;
    logic [STEP_W-1:0]   r_step;
    logic                r_h;
    logic                r_done;
    logic [IDX_W-1:0]    r_last;

    logic [NREQ-1:0]     w_win;
    logic [IDX_W-1:0]    w_win_idx;
    logic                w_win_valid;
    logic [STEP_W-1:0]   w_step_inc;

    assign w_step_inc = r_step + STEP_W'(1);

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req   (req),
        .i_last  (r_last),
        .o_win   (w_win),
        .o_idx   (w_win_idx),
        .o_valid (w_win_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ctrl  <= CTRL_IDLE;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_step  <= '0;
            r_h     <= 1'b0;
            r_done  <= 1'b0;
            r_last  <= IDX_W'(NREQ - 1);
        end else begin
            r_ack  <= '0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_win_valid) begin
                        r_state <= ST_LOAD;
                        r_ctrl  <= CTRL_LOAD;
                        r_gnt   <= w_win;
                        r_last  <= w_win_idx;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_RUN;
                    r_ctrl  <= CTRL_RUN;
                    r_step  <= '0;
                    r_h     <= 1'b0;
                end
                ST_RUN: begin
                    // An aborted job leaves r_last on its owner so rotation continues past it.
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_ctrl  <= CTRL_IDLE;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_step  <= '0;
                        r_h     <= 1'b0;
                    end else if (r_step == STEP_LAST) begin
                        r_state <= ST_FINISH;
                        r_ctrl  <= CTRL_FINISH;
                        r_step  <= '0;
                        r_h     <= 1'b0;
                    end else begin
                        r_step <= w_step_inc;
                        r_h    <= w_step_inc[0];
                    end
                end
                ST_FINISH: begin
                    // ack/done land in the cycle after FINISH, alongside the idle gap.
                    r_state <= ST_IDLE;
                    r_ctrl  <= CTRL_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_ack   <= r_gnt;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ctrl  <= CTRL_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_step  <= '0;
                    r_h     <= 1'b0;
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign ack  = r_ack;
    assign busy = r_busy;
    assign step = r_step;
    assign m0   = r_ctrl.m0;
    assign m1   = r_ctrl.m1;
    assign m2   = r_ctrl.m2;
    assign lx   = r_ctrl.lx;
    assign ls   = r_ctrl.ls;
    assign lh   = r_ctrl.lh;
    assign h    = r_h;
    assign done = r_done;

endmodule

// File: tb/tb_dp_arbiter_seq.sv
// Scoreboard bench for dp_arbiter_seq: a job-timeline reference model pushes
// expected outputs per cycle; a monitor pops and compares on every cycle.
module tb_dp_arbiter_seq;

    localparam int NREQ  = 4;
    localparam int STEPS = 7;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] ack;
        logic       busy;
        logic [3:0] step;
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       lx;
        logic       ls;
        logic       lh;
        logic       h;
        logic       done;
    } obs_t;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req;
    logic            abort;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] ack;
    logic            busy;
    logic [3:0]      step;
    logic [1:0]      m0;
    logic [1:0]      m1;
    logic [1:0]      m2;
    logic            lx;
    logic            ls;
    logic            lh;
    logic            h;
    logic            done;

    int errors = 0;
    int checks = 0;

    obs_t       exp_q[$];
    logic [3:0] ack_q[$];

    dp_arbiter_seq #(.NREQ(NREQ), .STEPS(STEPS)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .abort (abort),
        .gnt   (gnt),
        .ack   (ack),
        .busy  (busy),
        .step  (step),
        .m0    (m0),
        .m1    (m1),
        .m2    (m2),
        .lx    (lx),
        .ls    (ls),
        .lh    (lh),
        .h     (h),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs from a job's position k: 0 = load, 1..STEPS = run, STEPS+1 = finish.
    function automatic obs_t expect_of(input int owner, input int k, input int ack_owner);
        obs_t o;
        o = '0;
        if (owner >= 0) begin
            o.gnt  = 4'(1 << owner);
            o.busy = 1'b1;
            if (k == 0) begin
                o.lx = 1'b1;
                o.lh = 1'b1;
            end else if (k <= STEPS) begin
                o.ls   = 1'b1;
                o.m0   = 2'b01;
                o.m1   = 2'b10;
                o.m2   = 2'b01;
                o.step = 4'(k - 1);
                o.h    = 1'((k - 1) % 2);
            end else begin
                o.m2 = 2'b11;
            end
        end
        if (ack_owner >= 0) begin
            o.ack  = 4'(1 << ack_owner);
            o.done = 1'b1;
        end
        return o;
    endfunction

    int m_last  = NREQ - 1;
    int m_owner = -1;
    int m_k     = 0;

    always @(posedge clk) begin
        int new_ack;
        int cand;
        new_ack = -1;
        if (!rst) begin
            m_last  = NREQ - 1;
            m_owner = -1;
            m_k     = 0;
        end else if (m_owner < 0) begin
            for (int i = 1; i <= NREQ; i++) begin
                cand = (m_last + i) % NREQ;
                if (m_owner < 0 && req[cand]) begin
                    m_owner = cand;
                    m_last  = cand;
                    m_k     = 0;
                end
            end
        end else if (m_k >= 1 && m_k <= STEPS && abort) begin
            m_owner = -1;
        end else if (m_k == STEPS + 1) begin
            new_ack = m_owner;
            m_owner = -1;
        end else begin
            m_k++;
        end
        exp_q.push_back(expect_of(m_owner, m_k, new_ack));
        if (new_ack >= 0) ack_q.push_back(4'(1 << new_ack));
    end

    always @(negedge clk) begin
        obs_t e;
        obs_t g;
        logic [3:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g.gnt  = gnt;
            g.ack  = ack;
            g.busy = busy;
            g.step = step;
            g.m0   = m0;
            g.m1   = m1;
            g.m2   = m2;
            g.lx   = lx;
            g.ls   = ls;
            g.lh   = lh;
            g.h    = h;
            g.done = done;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got=%h exp=%h", $time, g, e);
            end
        end
        if (ack != '0) begin
            checks++;
            if (ack_q.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected t=%0t got=%b exp=none", $time, ack);
            end else begin
                a = ack_q.pop_front();
                if (ack !== a) begin
                    errors++;
                    $display("FAIL ack_order t=%0t got=%b exp=%b", $time, ack, a);
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, expv);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s t=%0t got=timeout exp=event", nm, $time);
    endtask

    task automatic wait_gnt(input bit nonzero, input string nm);
        int n;
        n = 0;
        while (((gnt != '0) != nonzero) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) timeout(nm);
    endtask

    task automatic wait_run(input logic [3:0] g, input int s, input string nm);
        int n;
        n = 0;
        while (!(gnt == g && int'(step) == s && busy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) timeout(nm);
    endtask

    task automatic wait_ack(output int cnt, input string nm);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (ack == '0 && cnt < 60);
        if (cnt >= 60) timeout(nm);
    endtask

    initial begin
        int order[5];
        int n;
        order = '{1, 2, 4, 8, 1};
        rst   = 1'b0;
        req   = 4'hF;
        abort = 1'b0;

        // reset with all requesting, then rotation from requester 0
        repeat (2) @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(1'b1, "rr_gnt_wait");
            chk("rr_order", int'(gnt), order[i]);
            wait_gnt(1'b0, "rr_idle_wait");
        end
        req = '0;
        repeat (15) @(negedge clk);

        // single job latency
        req = 4'h4;
        wait_ack(n, "single_ack_wait");
        chk("single_latency", n, STEPS + 3);
        chk("single_ack", int'(ack), 4);
        req = '0;
        repeat (3) @(negedge clk);

        // abort mid-run
        req = 4'h2;
        wait_run(4'h2, 3, "abort_run_wait");
        abort = 1'b1;
        req   = 4'h3;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_ack", int'(ack), 0);
        wait_gnt(1'b1, "abort_next_wait");
        chk("abort_next_gnt", int'(gnt), 1);
        req = '0;
        repeat (15) @(negedge clk);

        // owner drops req mid-job
        req = 4'h8;
        wait_run(4'h8, 2, "drop_run_wait");
        req = '0;
        wait_ack(n, "drop_ack_wait");
        chk("drop_ack", int'(ack), 8);
        chk("drop_ack_time", n, STEPS + 1 - 2);
        repeat (3) @(negedge clk);

        // reset during run
        req = 4'h1;
        wait_run(4'h1, 4, "rstrun_wait");
        rst = 1'b0;
        req = 4'h8;
        @(negedge clk);
        chk("rstrun_gnt", int'(gnt), 0);
        chk("rstrun_busy", int'(busy), 0);
        chk("rstrun_step", int'(step), 0);
        rst = 1'b1;
        wait_gnt(1'b1, "rstrun_gnt_wait");
        chk("rstrun_next_gnt", int'(gnt), 8);
        req = '0;
        repeat (15) @(negedge clk);

        // random traffic against the model
        repeat (600) begin
            rst   = ($urandom_range(0, 149) != 0);
            abort = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        rst   = 1'b1;
        abort = 1'b0;
        req   = '0;
        repeat (15) @(negedge clk);

        chk("ack_queue_drained", ack_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
